async_fifo_rptr_empty: RTL

Read-side pointer and empty-flag stage of the async FIFO.
- Receives the write-domain Gray write pointer and passes it through a two-flop synchronizer.
- Converts the synchronized pointer to binary through g2b_core.
- Maintains the binary and Gray read pointers.
- Produces the registered empty, almost-empty and read-count outputs consumed by the read-side logic and the FIFO RAM read port.

---
 rtl/async_fifo_pkg.sv | 20 ++
 rtl/g2b_core.sv | 19 +
 rtl/async_fifo_rptr_empty.sv | 88 ++++++++
 3 files changed

// File: rtl/async_fifo_pkg.sv
// Shared helpers for the async FIFO pointer stages: pointer width
// derivation and binary-to-Gray conversion.
package async_fifo_pkg;

    // Address width for a FIFO of the given depth.
    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Pointer width: one extra bit tells the laps apart, so full != empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Binary to reflected Gray; callers truncate the result to their width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/g2b_core.sv
// Combinational Gray-to-binary converter for a FIFO pointer of DEPTH entries.
// Each binary bit is the XOR of the Gray bits at and above its position.
module g2b_core
    import async_fifo_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic [$clog2(DEPTH):0] gray_i,
    output logic [$clog2(DEPTH):0] bin_o
);

    localparam int PW = ptr_width(DEPTH);

    // Prefix-XOR from the MSB downward.
    for (genvar i = 0; i < PW; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[PW-1:i];
    end

endmodule

// File: rtl/async_fifo_rptr_empty.sv
// Read-side pointer and empty-flag stage of the async FIFO.
// Synchronizes the write Gray pointer into clk_i, keeps the read pointers,
// and registers empty / almost-empty / read-count for the consumer.
module async_fifo_rptr_empty
    import async_fifo_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int AE_THRESH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH):0]   wptr_gray_i,
    output logic [$clog2(DEPTH):0]   rptr_gray_o,
    output logic [$clog2(DEPTH)-1:0] raddr_o,
    output logic                     empty_o,
    output logic                     almost_empty_o,
    output logic [$clog2(DEPTH):0]   rd_count_o
);

    localparam int AW = addr_width(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    logic [PW-1:0] sync1_q;
    logic [PW-1:0] wq2_gray_q;
    logic [PW-1:0] wq2_bin;
    logic [PW-1:0] rbin_q,  rbin_d;
    logic [PW-1:0] rgray_q, rgray_d;
    logic [PW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    logic          ae_q,    ae_d;
    logic          rd_fire;

    // Two-flop synchronizer for the write pointer; no logic between stages.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q    <= '0;
            wq2_gray_q <= '0;
        end else begin
            sync1_q    <= wptr_gray_i;
            wq2_gray_q <= sync1_q;
        end
    end

    g2b_core #(
        .DEPTH (DEPTH)
    ) u_g2b (
        .gray_i (wq2_gray_q),
        .bin_o  (wq2_bin)
    );

    // Next read pointer and flags; a read while empty is silently dropped.
    always_comb begin
        rd_fire = rd_en_i & ~empty_q;
        rbin_d  = rbin_q + PW'(rd_fire);
        rgray_d = PW'(bin2gray(32'(rbin_d)));
        count_d = wq2_bin - rbin_d;
        empty_d = (rgray_d == wq2_gray_q);
        ae_d    = (count_d <= PW'(AE_THRESH));
    end

    // Read pointer and status registers; empty and almost-empty reset high.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rbin_q  <= '0;
            rgray_q <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            ae_q    <= 1'b1;
        end else begin
            rbin_q  <= rbin_d;
            rgray_q <= rgray_d;
            count_q <= count_d;
            empty_q <= empty_d;
            ae_q    <= ae_d;
        end
    end

    // Outputs come straight from registers; raddr is the current read entry.
    always_comb begin
        rptr_gray_o    = rgray_q;
        raddr_o        = rbin_q[AW-1:0];
        empty_o        = empty_q;
        almost_empty_o = ae_q;
        rd_count_o     = count_q;
    end

endmodule
